// File: rtl/life_manager_if.sv
`default_nettype none
// ============================================================================
// Module  : life_manager_if
// Brief   : Frame/death/restart inputs and lives/status outputs of life_manager
// Revision: 1.0
// ============================================================================
interface life_manager_if #(
  parameter int LIVES_W = 2
);
  logic               frame_tick;
  logic               death_signal;
  logic               restart;
  logic [LIVES_W-1:0] lives;
  logic               dying;
  logic               invuln;
  logic               respawn;
  logic               game_over;

  modport master (
    output frame_tick, death_signal, restart,
    input  lives, dying, invuln, respawn, game_over
  );

  modport slave (
    input  frame_tick, death_signal, restart,
    output lives, dying, invuln, respawn, game_over
  );
endinterface
`default_nettype wire

// File: rtl/life_manager.sv
`default_nettype none
// ============================================================================
// Module  : life_manager
// Brief   : Lives counter with death-freeze and respawn invulnerability windows
// Revision: 1.0
// ============================================================================
module life_manager #(
  parameter int LIVES         = 3,
  parameter int LIVES_W       = 2,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int FRM_W         = 8
) (
  input  wire logic      sys_clk,
  input  wire logic      Reset,
  life_manager_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_DYING  = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
  localparam logic [FRM_W-1:0]   DEATH_LAST  = FRM_W'(DEATH_FRAMES - 1);
  localparam logic [FRM_W-1:0]   INVULN_LAST = FRM_W'(INVULN_FRAMES - 1);
  localparam logic [FRM_W-1:0]   FRM_MAX     = {FRM_W{1'b1}};
  localparam logic [FRM_W-1:0]   FRM_ONE     = FRM_W'(1);

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [FRM_W-1:0]   frame_q, frame_d;
  logic               respawn_q, respawn_d;
  logic               dying_q, dying_d;
  logic               invuln_q, invuln_d;
  logic               over_q, over_d;

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_PLAY;
      lives_q   <= LIVES_INIT;
      frame_q   <= '0;
      respawn_q <= 1'b0;
      dying_q   <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      frame_q   <= frame_d;
      respawn_q <= respawn_d;
      dying_q   <= dying_d;
      invuln_q  <= invuln_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    frame_d   = frame_q;
    respawn_d = 1'b0;

    case (state_q)
      ST_PLAY: begin
        // A coincident frame_tick is deliberately dropped: DYING starts at 0.
        if (bus.death_signal) begin
          frame_d = '0;
          if (lives_q > LIVES_ONE) begin
            lives_d = lives_q - LIVES_ONE;
            state_d = ST_DYING;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
          end
        end
      end

      ST_DYING: begin
        if (bus.frame_tick) begin
          if (frame_q == DEATH_LAST) begin
            frame_d   = '0;
            respawn_d = 1'b1;
            state_d   = ST_INVULN;
          end else if (frame_q != FRM_MAX) begin
            frame_d = frame_q + FRM_ONE;
          end
        end
      end

      ST_INVULN: begin
        if (bus.frame_tick) begin
          if (frame_q == INVULN_LAST) begin
            frame_d = '0;
            state_d = ST_PLAY;
          end else if (frame_q != FRM_MAX) begin
            frame_d = frame_q + FRM_ONE;
          end
        end
      end

      ST_OVER: begin
        lives_d = '0;
        if (bus.restart) begin
          lives_d   = LIVES_INIT;
          frame_d   = '0;
          respawn_d = 1'b1;
          state_d   = ST_INVULN;
        end
      end

      default: begin
        state_d = ST_PLAY;
      end
    endcase

    // Flags follow the next state so they are true registers, not decodes.
    dying_d  = (state_d == ST_DYING);
    invuln_d = (state_d == ST_INVULN);
    over_d   = (state_d == ST_OVER);
  end

  assign bus.lives     = lives_q;
  assign bus.dying     = dying_q;
  assign bus.invuln    = invuln_q;
  assign bus.respawn   = respawn_q;
  assign bus.game_over = over_q;

endmodule
`default_nettype wire
